// File: rtl/snake_pkg.sv
// Shared types for the Snake direction controller: heading encoding, reset heading, reversal helper.
package snake_pkg;

   typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

   localparam dir_t DIR_RESET = DIR_RIGHT;

   // Opposite heading: flipping bit 1 swaps UP<->DOWN and RIGHT<->LEFT.
   function automatic dir_t reverse(input dir_t d);
      return dir_t'(2'(d) ^ 2'd2);
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular queue of pending headings; simultaneous push and pop are allowed, even when full.
// Exposes the head (next heading to apply) and the tail (most recently queued heading).
module dir_fifo
   import snake_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  dir_t                          i_data,
   output dir_t                          o_head,
   output dir_t                          o_tail,
   output logic [$clog2(QDEPTH+1)-1:0]   o_count
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = $clog2(QDEPTH + 1);

   dir_t            r_mem [QDEPTH];
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [CW-1:0]   r_count;

   logic            w_full;
   logic            w_do_pop;
   logic            w_do_push;
   logic [PW-1:0]   w_tail_idx;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : PW'(p + PW'(1));
   endfunction

   assign w_full     = (r_count == CW'(QDEPTH));
   assign w_do_pop   = i_pop && (r_count != '0);
   // A pop in the same cycle frees the slot the push needs.
   assign w_do_push  = i_push && (!w_full || w_do_pop);
   assign w_tail_idx = (r_wr == '0) ? PW'(QDEPTH - 1) : PW'(r_wr - PW'(1));

   assign o_head  = r_mem[r_rd];
   assign o_tail  = r_mem[w_tail_idx];
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(QDEPTH); i++) r_mem[i] <= DIR_RESET;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ptr_inc(r_wr);
         end
         if (w_do_pop) r_rd <= ptr_inc(r_rd);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= CW'(r_count + CW'(1));
            2'b01:   r_count <= CW'(r_count - CW'(1));
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/snake_dir_arbiter.sv
// Snake heading controller: round-robin key arbitration, turn filtering, queued turns applied one per tick.
// Optional macro REVERSE_GUARD_EN rejects 180-degree turns against the reference heading.
module snake_dir_arbiter
   import snake_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_key_up,
   input  logic                          i_key_right,
   input  logic                          i_key_down,
   input  logic                          i_key_left,
   input  logic                          i_tick,
   output dir_t                          o_dir,
   output logic                          o_step,
   output logic [$clog2(QDEPTH+1)-1:0]   o_pending,
   output logic                          o_drop
);

   localparam int unsigned CW = $clog2(QDEPTH + 1);

   dir_t            r_dir;
   logic [1:0]      r_rr;
   logic            r_step;
   logic            r_drop;

   logic [3:0]      w_keys;
   logic [1:0]      w_gidx;
   logic [1:0]      w_idx;
   logic            w_any;
   dir_t            w_grant;
   dir_t            w_head;
   dir_t            w_tail;
   dir_t            w_ref;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_occ;
   logic            w_pop;
   logic            w_full;
   logic            w_dup;
   logic            w_rev;
   logic            w_push;
   logic            w_losers;
   logic            w_drop;

   assign w_keys = {i_key_left, i_key_down, i_key_right, i_key_up};

   // First asserted key at or after the round-robin pointer.
   always_comb begin
      w_gidx = 2'd0;
      w_any  = 1'b0;
      w_idx  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         w_idx = 2'(r_rr + 2'(i));
         if (!w_any && w_keys[w_idx]) begin
            w_gidx = w_idx;
            w_any  = 1'b1;
         end
      end
   end

   assign w_grant  = dir_t'(w_gidx);
   assign w_losers = |(w_keys & ~(4'b0001 << w_gidx));

   // Filtering uses pre-pop state, with this cycle's pop credited to occupancy.
   assign w_pop  = i_tick && (w_count != '0);
   assign w_ref  = (w_count != '0) ? w_tail : r_dir;
   assign w_occ  = CW'(w_count - CW'(w_pop));
   assign w_full = (w_occ == CW'(QDEPTH));
   assign w_dup  = (w_grant == w_ref);
`ifdef REVERSE_GUARD_EN
   assign w_rev  = (w_grant == reverse(w_ref));
`else
   assign w_rev  = 1'b0;
`endif
   assign w_push = w_any && !w_dup && !w_rev && !w_full;
   assign w_drop = w_losers || (w_any && !w_dup && (w_rev || w_full));

   dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_grant),
      .o_head  (w_head),
      .o_tail  (w_tail),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dir  <= DIR_RESET;
         r_rr   <= 2'd0;
         r_step <= 1'b0;
         r_drop <= 1'b0;
      end else begin
         r_step <= i_tick;
         r_drop <= w_drop;
         if (w_any) r_rr  <= 2'(w_gidx + 2'd1);
         if (w_pop) r_dir <= w_head;
      end
   end

   assign o_dir     = r_dir;
   assign o_step    = r_step;
   assign o_drop    = r_drop;
   assign o_pending = w_count;

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Directed self-checking bench for snake_dir_arbiter (QDEPTH=2); expectations follow REVERSE_GUARD_EN.
module tb_snake_dir_arbiter;
   import snake_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       key_up, key_right, key_down, key_left, tick;
   dir_t       dir;
   logic       step;
   logic [1:0] pending;
   logic       drop;

   int n_checks = 0;
   int n_fail   = 0;

   snake_dir_arbiter #(.QDEPTH(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_key_up    (key_up),
      .i_key_right (key_right),
      .i_key_down  (key_down),
      .i_key_left  (key_left),
      .i_tick      (tick),
      .o_dir       (dir),
      .o_step      (step),
      .o_pending   (pending),
      .o_drop      (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive keys {left,down,right,up} and tick for one cycle; return #1 after the sampling edge.
   task automatic cyc(input logic [3:0] k, input logic t);
      key_up = k[0]; key_right = k[1]; key_down = k[2]; key_left = k[3]; tick = t;
      @(posedge clk); #1;
      key_up = 0; key_right = 0; key_down = 0; key_left = 0; tick = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      key_up = 0; key_right = 0; key_down = 0; key_left = 0; tick = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL reset_dir got=%0d want=%0d", dir, DIR_RIGHT); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending got=%0d want=0", pending); end
      n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%0b want=0", step); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%0b want=0", drop); end
   endtask

   task automatic test_basic_turn();
      do_reset();
      cyc(4'b0001, 1'b0);
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL basic_pending got=%0d want=1", pending); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL basic_drop got=%0b want=0", drop); end
      n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL basic_dir_before_tick got=%0d want=%0d", dir, DIR_RIGHT); end
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL basic_dir got=%0d want=%0d", dir, DIR_UP); end
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL basic_step got=%0b want=1", step); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL basic_pending_after got=%0d want=0", pending); end
      cyc(4'b0000, 1'b0);
      n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL basic_step_one_cycle got=%0b want=0", step); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL empty_tick_dir got=%0d want=%0d", dir, DIR_UP); end
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL empty_tick_step got=%0b want=1", step); end
   endtask

   task automatic test_reverse();
      do_reset();
      cyc(4'b1000, 1'b0);
`ifdef REVERSE_GUARD_EN
      n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL rev_drop got=%0b want=1", drop); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL rev_pending got=%0d want=0", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL rev_dir got=%0d want=%0d", dir, DIR_RIGHT); end
`else
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rev_drop got=%0b want=0", drop); end
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL rev_pending got=%0d want=1", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL rev_dir got=%0d want=%0d", dir, DIR_LEFT); end
`endif
   endtask

   task automatic test_round_robin();
      do_reset();
      cyc(4'b0101, 1'b0);  // UP wins from rr=UP, DOWN loses
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL rr1_pending got=%0d want=1", pending); end
      n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL rr1_drop got=%0b want=1", drop); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL rr1_dir got=%0d want=%0d", dir, DIR_UP); end
      cyc(4'b0101, 1'b0);  // rr=RIGHT now: DOWN wins, UP loses
      n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL rr2_drop got=%0b want=1", drop); end
`ifdef REVERSE_GUARD_EN
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL rr2_pending got=%0d want=0", pending); end
`else
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL rr2_pending got=%0d want=1", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL rr2_dir got=%0d want=%0d", dir, DIR_DOWN); end
`endif
   endtask

   task automatic test_full();
      do_reset();
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
      n_checks++; if (pending !== 2'd2) begin n_fail++; $display("FAIL full_pending got=%0d want=2", pending); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL full_second_drop got=%0b want=0", drop); end
      cyc(4'b0100, 1'b0);
      n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL full_drop got=%0b want=1", drop); end
      n_checks++; if (pending !== 2'd2) begin n_fail++; $display("FAIL full_pending_hold got=%0d want=2", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL full_tick1_dir got=%0d want=%0d", dir, DIR_UP); end
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL full_tick1_pending got=%0d want=1", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL full_tick2_dir got=%0d want=%0d", dir, DIR_LEFT); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL full_tick2_pending got=%0d want=0", pending); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0100, 1'b1);  // press into full queue on a tick: accepted
      n_checks++; if (pending !== 2'd2) begin n_fail++; $display("FAIL b2b_pending got=%0d want=2", pending); end
      n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL b2b_dir got=%0d want=%0d", dir, DIR_UP); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got=%0b want=0", drop); end
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL b2b_step got=%0b want=1", step); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL b2b_tick2_dir got=%0d want=%0d", dir, DIR_LEFT); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL b2b_tick3_dir got=%0d want=%0d", dir, DIR_DOWN); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL b2b_drained got=%0d want=0", pending); end
      cyc(4'b1000, 1'b1);  // push into empty queue on a tick: not applied yet
      n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL empty_push_dir got=%0d want=%0d", dir, DIR_DOWN); end
      n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL empty_push_pending got=%0d want=1", pending); end
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL empty_push_apply got=%0d want=%0d", dir, DIR_LEFT); end
      cyc(4'b1000, 1'b0);  // duplicate of current heading
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL dup_pending got=%0d want=0", pending); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL dup_drop got=%0b want=0", drop); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(4'b0100, 1'b0);
      cyc(4'b0000, 1'b1);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      n_checks++; if (pending !== 2'd2) begin n_fail++; $display("FAIL mid_setup_pending got=%0d want=2", pending); end
      n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL mid_setup_dir got=%0d want=%0d", dir, DIR_DOWN); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL mid_rst_dir got=%0d want=%0d", dir, DIR_RIGHT); end
      n_checks++; if (pending !== 2'd0) begin n_fail++; $display("FAIL mid_rst_pending got=%0d want=0", pending); end
      n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL mid_rst_step got=%0b want=0", step); end
      n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL mid_rst_drop got=%0b want=0", drop); end
      @(posedge clk); #1 rst_n = 1'b1;
      cyc(4'b0000, 1'b1);
      n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL mid_after_tick_dir got=%0d want=%0d", dir, DIR_RIGHT); end
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL mid_after_tick_step got=%0b want=1", step); end
   endtask

   initial begin
      rst_n = 1'b0;
      key_up = 0; key_right = 0; key_down = 0; key_left = 0; tick = 0;
      test_reset();
      test_basic_turn();
      test_reverse();
      test_round_robin();
      test_full();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/snake_dir_arbiter.md
# snake_dir_arbiter

Direction controller for the Snake game. It takes the four single-cycle key pulses produced by the per-button edge-detect stages, arbitrates simultaneous presses round-robin, and filters out illegal or redundant turns. Accepted turns are buffered in a small queue and applied to the snake heading one per game tick, so the movement engine sees exactly one heading change per step.

## Interface
- QDEPTH, 2, depth of the pending-turn queue (legal 1..4).

- Clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately; release is synchronous to Clock.
- key_up, key_right, key_down, key_left  in  1 each  one-cycle press pulses.
- tick  in  1  one-cycle game-step strobe.
- dir  out  2  current heading (dir_t).
- step  out  1  registered pulse one cycle after each tick.
- pending  out  $clog2(QDEPTH+1)  number of queued turns.
- drop  out  1  registered pulse: a press was discarded in the previous cycle.

## Operation
- Encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3. The reverse of d is d^2.
- Arbitration:
  - Among the keys asserted in a cycle, grant the first at or after rr_ptr, in order UP, RIGHT, DOWN, LEFT.
  - On a grant, rr_ptr <= grant+1 (mod 4). With no keys asserted, rr_ptr holds.
- Reference heading = last queued entry if pending>0, else dir.
- Grant filtering:
  - If grant == reference, it is a duplicate: ignored silently, no drop.
  - If grant == reference^2, it is a reversal (only with REVERSE_GUARD_EN): rejected, drop.
  - If the effective occupancy is full (pending minus pop-this-cycle == QDEPTH), it is rejected with drop.
  - Otherwise the grant is pushed.
- Arbitration losers (any key asserted but not granted) also cause drop.
- On tick with pending>0:
  - dir <= queue head, and the head is popped.
  - With pending==0, dir holds.
  - step pulses in either case.
- Simultaneous tick and press:
  - The reference heading and the full check use pre-pop state, with the pop credited to occupancy.
  - A press into a full queue on a tick cycle is accepted.
  - If the pushed entry lands in an empty queue, it is not applied until the next tick.
- Reset values: dir=RIGHT, queue empty, pending=0, rr_ptr=UP, step=0, drop=0.
- Asserting reset mid-game discards all queued turns immediately.

## Timing
- Press in cycle n: pending increments and drop is valid at n+1.
- Tick in cycle n: new dir and step=1 are both visible at n+1. step is high for exactly one cycle.
- A press at n followed by a tick at n+1 applies the turn at n+2.
- No combinational path from any input to any output.

## Configuration
- REVERSE_GUARD_EN defined:
  - A 180° turn against the reference heading is rejected with drop.
- REVERSE_GUARD_EN undefined:
  - Reversals are queued like any other turn.
  - The movement engine treats the result as self-collision.
  - Duplicate filtering is unaffected.

## Structure
- Package snake_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT};
  - DIR_RESET = DIR_RIGHT;
  - function reverse(dir_t).
- Sub-module dir_fifo:
  - Parameter QDEPTH, dir_t entries.
  - push, pop, head, count.
  - Defined push-and-pop-same-cycle behaviour (supported, including when full), asynchronous active-low reset.
- The arbiter, filter and heading register live in snake_dir_arbiter.

## Test plan
- Reset, then key_up at cycle 2 and tick at cycle 5:
  - pending=1 at cycle 3.
  - dir=UP and step=1 at cycle 6.
  - pending=0 at cycle 6.
- dir=RIGHT, key_left pulse:
  - With REVERSE_GUARD_EN: drop=1 next cycle, pending=0.
  - Without the macro: pending=1, and after tick dir=LEFT.
- key_up and key_down in the same cycle, rr_ptr=UP:
  - UP is queued and drop=1.
  - Repeating the pair after a tick queues DOWN, since rr_ptr=RIGHT; with the guard enabled and reference UP, DOWN is instead rejected.
- QDEPTH=2, dir=RIGHT, presses UP, LEFT, DOWN with no tick:
  - pending reaches 2.
  - The third press gives drop=1.
  - Two ticks yield dir=UP, then dir=LEFT.
- Full queue with a press and tick in the same cycle:
  - The press is accepted, pending stays 2.
  - dir takes the old head, drop=0.
- reset driven low mid-run with pending=2 and dir=DOWN:
  - Outputs immediately read dir=RIGHT, pending=0, step=0, drop=0.
  - A tick after release leaves dir=RIGHT.
